// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store controller: access widths, FSM states,
// default register-tag width and latency counter width.
// Imported by lsu_ctrl; holds no logic.
package lsu_ctrl_pkg;

  // Access width encodings, shared with data_mem_unit bit_width
  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;
  localparam logic [1:0] WIDTH_D = 2'b11;

  localparam int RD_W_DEF = 5;

  // Wide enough for MEM_LATENCY - 1 with MEM_LATENCY up to 4
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of data_mem_unit: one request in flight, tagged response.
// Latency from accept edge: fault +1 cycle, store +2, load MEM_LATENCY+1 to resp_valid.
// Backpressure: req_ready only in IDLE; resp_* held stable while resp_valid && !resp_ready.
// Ports: clk/rst; req_* from execute (valid/ready); resp_* to writeback (valid/ready);
//        mem_* drive data_mem_unit, mem_dout is its realigned/extended read data.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_BITS   = 15,
  parameter int RD_W        = RD_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [63:0]     req_addr,
  input  logic [63:0]     req_wdata,
  input  logic [1:0]      req_width,
  input  logic            req_signed,
  input  logic [RD_W-1:0] req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [63:0]     resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            resp_is_store,
  output logic            resp_fault,
  output logic            mem_en,
  output logic            mem_wea,
  output logic [63:0]     mem_addr,
  output logic [63:0]     mem_din,
  output logic            mem_sign_extend,
  output logic [1:0]      mem_bit_width,
  input  logic [63:0]     mem_dout
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              is_store_q;
  logic [63:0]       addr_q;
  logic [63:0]       wdata_q;
  logic [1:0]        width_q;
  logic              signed_q;
  logic [RD_W-1:0]   rd_q;
  logic [63:0]       rdata_q;
  logic              fault_q;

  logic accept;
  logic req_fault;
  logic cnt_done;

  assign accept    = (state == IDLE) && req_valid;
  assign req_fault = |req_addr[63:ADDR_BITS];
  // WAIT lasts MEM_LATENCY-1 cycles: exit on the edge where the counter reaches zero
  assign cnt_done  = (cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = req_fault ? RESP : ISSUE;
      ISSUE: state_nxt = (is_store_q || MEM_LATENCY == 1) ? RESP : WAIT;
      WAIT:  if (cnt_done) state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and memory strobe outputs
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_wea    = 1'b0;
    case (state)
      IDLE:  req_ready = 1'b1;
      ISSUE: begin
        mem_en  = 1'b1;
        mem_wea = is_store_q;
      end
      WAIT:  mem_en = 1'b1;
      RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch, latency counter and load-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      width_q    <= '0;
      signed_q   <= 1'b0;
      rd_q       <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (accept) begin
        is_store_q <= req_is_store;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        width_q    <= req_width;
        signed_q   <= req_signed;
        rd_q       <= req_rd;
        fault_q    <= req_fault;
        rdata_q    <= '0;  // stores and faults respond with zero data
      end
      if (state == ISSUE && !is_store_q) begin
        cnt <= CNT_W'(MEM_LATENCY - 1);
        if (MEM_LATENCY == 1) rdata_q <= mem_dout;
      end
      if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt_done) rdata_q <= mem_dout;
      end
    end
  end

  // mem_* address/data fields follow the latched request so they stay put across WAIT
  assign mem_addr        = addr_q;
  assign mem_din         = wdata_q;
  assign mem_bit_width   = width_q;
  assign mem_sign_extend = signed_q;

  assign resp_data     = rdata_q;
  assign resp_rd       = rd_q;
  assign resp_is_store = is_store_q;
  assign resp_fault    = fault_q;

endmodule
